vram_wb_px: RTL and testbench

Parametrised dual-port framebuffer VRAM for the Zucker GPU, the successor to the fixed 128x32x1bpp VRAM. Width, height and bit depth are configurable. A Wishbone slave port provides CPU access, and a registered pixel-fetch port feeds the scan-out logic. Adds a hardware fill/clear engine with busy status and a handshaked pixel port.

---
 rtl/vram_wb_px.sv | 145 ++++++++++++++
 tb/tb_vram_wb_px.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_wb_px.sv
// vram_wb_px: parametrised framebuffer VRAM with a Wishbone slave port, a
// pipelined pixel-fetch port and a fill/clear engine.
// Optional build macro VRAM_FILL_IRQ_EN adds irq_o (fill-complete interrupt).
module vram_wb_px #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 32,
  parameter int BPP    = 1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic [14:0]                wb_adr_i,
  input  logic [31:0]                wb_dat_i,
  output logic [31:0]                wb_dat_o,
  input  logic                       wb_we_i,
  input  logic [3:0]                 wb_sel_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_cyc_i,
  output logic                       wb_ack_o,
  input  logic [$clog2(WIDTH)-1:0]   gb_x_i,
  input  logic [$clog2(HEIGHT)-1:0]  gb_y_i,
  input  logic                       gb_req_i,
  output logic [BPP-1:0]             gb_pix_o,
  output logic                       gb_vld_o
`ifdef VRAM_FILL_IRQ_EN
  ,
  output logic                       irq_o
`endif
);

  localparam int WORDS = WIDTH * HEIGHT * BPP / 32;
  localparam int AW    = $clog2(WORDS);
  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int PPW   = 32 / BPP;
  localparam int LW    = $clog2(PPW);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [31:0]     r_pat;
  logic [31:0]     r_mem [WORDS];
  logic [31:0]     r_pword;
  logic [LW-1:0]   r_plane;
  logic            r_preq;

  logic            w_active, w_ctrl, w_busy, w_go;
  logic            w_fill_cmd, w_fill_last, w_vram_we, w_fill_rd;
  logic [AW-1:0]   w_wadr;
  logic [XW+YW-1:0] w_pidx;
  logic [AW-1:0]   w_pword_adr;
  logic [31:0]     w_ctrl_rd;
  logic [BPP-1:0]  w_pix;
  logic            w_unused_ok;

  assign w_active    = wb_cyc_i & wb_stb_i;
  assign w_ctrl      = wb_adr_i[14];
  assign w_busy      = (r_state == S_FILL);
  // VRAM-space accesses wait while the fill engine owns the memory.
  assign w_go        = w_active & ~wb_ack_o & ~(w_busy & ~w_ctrl);
  assign w_fill_cmd  = w_go & w_ctrl & wb_we_i & (wb_adr_i[1:0] == 2'd0);
  assign w_fill_rd   = w_go & w_ctrl & ~wb_we_i & (wb_adr_i[1:0] == 2'd0);
  assign w_fill_last = w_busy & (r_cnt == AW'(WORDS - 1));
  assign w_vram_we   = w_go & ~w_ctrl & wb_we_i;
  assign w_wadr      = wb_adr_i[AW-1:0];
  assign w_pidx      = {gb_y_i, gb_x_i};
  assign w_pword_adr = w_pidx[XW+YW-1:LW];
  assign w_pix       = BPP'(r_pword >> (int'(r_plane) * BPP));
  assign w_unused_ok = &{1'b0, wb_adr_i};

  // Control-space read data.
  always_comb begin
    w_ctrl_rd = '0;
    case (wb_adr_i[1:0])
      2'd0: begin
        w_ctrl_rd[0] = w_busy;
`ifdef VRAM_FILL_IRQ_EN
        w_ctrl_rd[1] = irq_o;
`endif
      end
      2'd1:    w_ctrl_rd = {12'(WIDTH), 12'(HEIGHT), 8'(BPP)};
      default: w_ctrl_rd = '0;
    endcase
  end

  // Fill engine next state: a new FILL command always (re)starts the fill.
  always_comb begin
    w_state_nxt = r_state;
    if (w_fill_cmd)       w_state_nxt = S_FILL;
    else if (w_fill_last) w_state_nxt = S_IDLE;
  end

  // Fill engine state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Fill counter/pattern, Wishbone response and pixel output stage.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cnt    <= '0;
      r_pat    <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      r_preq   <= 1'b0;
      gb_vld_o <= 1'b0;
      gb_pix_o <= '0;
    end else begin
      if (w_fill_cmd) begin
        r_pat <= {PPW{wb_dat_i[BPP-1:0]}};
        r_cnt <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + AW'(1);
      end
      wb_ack_o <= w_go;
      if (w_go) wb_dat_o <= w_ctrl ? w_ctrl_rd : r_mem[w_wadr];
      r_preq   <= gb_req_i;
      gb_vld_o <= r_preq;
      if (r_preq) gb_pix_o <= w_pix;
    end
  end

  // Storage (not reset): fill writes, byte-laned CPU writes, pixel word fetch.
  always_ff @(posedge wb_clk_i) begin
    if (w_busy) begin
      r_mem[r_cnt] <= r_pat;
    end else if (w_vram_we) begin
      for (int unsigned b = 0; b < 4; b++)
        if (wb_sel_i[b]) r_mem[w_wadr][8*b +: 8] <= wb_dat_i[8*b +: 8];
    end
    r_pword <= r_mem[w_pword_adr];
    r_plane <= w_pidx[LW-1:0];
  end

`ifdef VRAM_FILL_IRQ_EN
  // Fill-complete interrupt: natural end of a fill sets, FILL read clears, set wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                    irq_o <= 1'b0;
    else if (w_fill_last & ~w_fill_cmd) irq_o <= 1'b1;
    else if (w_fill_rd)                irq_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_vram_wb_px.sv
// Directed self-checking bench for vram_wb_px: default geometry instance plus a
// 16x8x4bpp instance for pixel-lane mapping.
module tb_vram_wb_px;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_sel = '0;
  logic        wb_cyc = 1'b0;
  logic        stb0 = 1'b0, stb4 = 1'b0;
  logic [31:0] dat0, dat4;
  logic        ack0, ack4;
  logic [6:0]  x0 = '0;
  logic [4:0]  y0 = '0;
  logic        req0 = 1'b0;
  logic [0:0]  pix0;
  logic        vld0;
  logic [3:0]  x4 = '0;
  logic [2:0]  y4 = '0;
  logic        req4 = 1'b0;
  logic [3:0]  pix4;
  logic        vld4;
`ifdef VRAM_FILL_IRQ_EN
  logic        irq0, irq4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vram_wb_px dut0 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
    .wb_dat_o(dat0), .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_stb_i(stb0),
    .wb_cyc_i(wb_cyc), .wb_ack_o(ack0), .gb_x_i(x0), .gb_y_i(y0),
    .gb_req_i(req0), .gb_pix_o(pix0), .gb_vld_o(vld0)
`ifdef VRAM_FILL_IRQ_EN
    , .irq_o(irq0)
`endif
  );

  vram_wb_px #(.WIDTH(16), .HEIGHT(8), .BPP(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
    .wb_dat_o(dat4), .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_stb_i(stb4),
    .wb_cyc_i(wb_cyc), .wb_ack_o(ack4), .gb_x_i(x4), .gb_y_i(y4),
    .gb_req_i(req4), .gb_pix_o(pix4), .gb_vld_o(vld4)
`ifdef VRAM_FILL_IRQ_EN
    , .irq_o(irq4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One Wishbone transfer on instance d (0 or 4); lat = edges until ack.
  task automatic wb_xfer(input int d, input logic we, input logic [14:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         output logic [31:0] rd, output int lat);
    logic got;
    @(negedge clk);
    wb_adr = adr; wb_dat = dat; wb_we = we; wb_sel = sel; wb_cyc = 1'b1;
    stb0 = (d == 0); stb4 = (d == 4);
    lat = 0; got = 1'b0;
    while (!got && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      got = (d == 0) ? ack0 : ack4;
    end
    rd = (d == 0) ? dat0 : dat4;
    stb0 = 1'b0; stb4 = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
      chk("ack_single_pulse", 32'((d == 0) ? ack0 : ack4), 32'd0);
    end
  endtask

  // Stream all 4096 pixels of dut0 back to back; count wrong/invalid returns.
  task automatic pix_sweep(input logic exp, output int bad);
    bad = 0;
    for (int c = 0; c <= 4096; c++) begin
      @(negedge clk);
      req0 = (c < 4096);
      {y0, x0} = 12'(c);
      @(posedge clk); #1;
      if (c >= 1 && (vld0 !== 1'b1 || pix0 !== exp)) bad++;
    end
    @(negedge clk);
    req0 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat, bad;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack0), 32'd0);
    chk("rst_vld", 32'(vld0), 32'd0);
    chk("rst_pix", 32'(pix0), 32'd0);
    chk("rst_dat", dat0, 32'd0);
    chk("rst_pix4", 32'(pix4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Control space at idle.
    wb_xfer(0, 1'b0, 15'h4000, '0, 4'hF, rd, lat);
    chk("fill_rd_idle", rd, 32'h0000_0000);
    chk("ctrl_lat", 32'(lat), 32'd1);
    wb_xfer(0, 1'b0, 15'h4001, '0, 4'hF, rd, lat);
    chk("geom_default", rd, 32'h0800_2001);
    wb_xfer(0, 1'b0, 15'h4002, '0, 4'hF, rd, lat);
    chk("ctrl_off2_rd", rd, 32'h0);
    wb_xfer(0, 1'b1, 15'h4003, 32'hFFFF_FFFF, 4'hF, rd, lat);
    wb_xfer(0, 1'b0, 15'h4000, '0, 4'hF, rd, lat);
    chk("off3_wr_ignored", rd, 32'h0);

    // Byte lanes.
    wb_xfer(0, 1'b1, 15'd0, 32'hFFFF_FFFF, 4'hF, rd, lat);
    wb_xfer(0, 1'b1, 15'd0, 32'h0000_0000, 4'b0101, rd, lat);
    wb_xfer(0, 1'b0, 15'd0, '0, 4'hF, rd, lat);
    chk("byte_lanes", rd, 32'hFF00_FF00);
    chk("vram_rd_lat", 32'(lat), 32'd1);

    // Aliasing modulo WORDS and read-before-write.
    wb_xfer(0, 1'b1, 15'd133, 32'hA5A5_5A5A, 4'hF, rd, lat);
    wb_xfer(0, 1'b0, 15'd5, '0, 4'hF, rd, lat);
    chk("alias_rd", rd, 32'hA5A5_5A5A);
    wb_xfer(0, 1'b1, 15'd5, 32'h1234_5678, 4'hF, rd, lat);
    chk("rd_before_wr", rd, 32'hA5A5_5A5A);
    wb_xfer(0, 1'b0, 15'd5, '0, 4'hF, rd, lat);
    chk("wr_then_rd", rd, 32'h1234_5678);

    // 4bpp instance: geometry and lane mapping through the pixel pipeline.
    wb_xfer(4, 1'b0, 15'h4001, '0, 4'hF, rd, lat);
    chk("geom_4bpp", rd, 32'h0100_0804);
    wb_xfer(4, 1'b1, 15'd1, 32'h8765_4321, 4'hF, rd, lat);
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      req4 = (c < 8);
      x4 = 4'(8 + c);
      y4 = '0;
      @(posedge clk); #1;
      if (c >= 1 && c <= 8) begin
        chk("pix4_vld", 32'(vld4), 32'd1);
        chk("pix4_val", 32'(pix4), 32'(c));
      end else if (c == 0) begin
        chk("pix4_idle_vld", 32'(vld4), 32'd0);
      end else begin
        chk("pix4_end_vld", 32'(vld4), 32'd0);
        chk("pix4_hold", 32'(pix4), 32'd8);
      end
    end
    @(negedge clk);
    req4 = 1'b0;

    // Fill with 1: VRAM read stalls until busy has been high for 128 cycles.
    wb_xfer(0, 1'b1, 15'h4000, 32'h1, 4'hF, rd, lat);
    wb_xfer(0, 1'b0, 15'h4000, '0, 4'hF, rd, lat);
    chk("busy_during_fill", rd, 32'h1);
    chk("ctrl_lat_busy", 32'(lat), 32'd1);
    wb_xfer(0, 1'b0, 15'd7, '0, 4'hF, rd, lat);
    chk("stalled_rd_lat", 32'(lat), 32'd126);
    chk("stalled_rd_data", rd, 32'hFFFF_FFFF);
`ifdef VRAM_FILL_IRQ_EN
    chk("irq_set", 32'(irq0), 32'd1);
    wb_xfer(0, 1'b0, 15'h4000, '0, 4'hF, rd, lat);
    chk("fill_rd_irq", rd, 32'h2);
    chk("irq_cleared", 32'(irq0), 32'd0);
`else
    wb_xfer(0, 1'b0, 15'h4000, '0, 4'hF, rd, lat);
    chk("fill_rd_done", rd, 32'h0);
`endif
    pix_sweep(1'b1, bad);
    chk("pix_all_ones", 32'(bad), 32'd0);

    // Restart: fill with 1, then with 0 ten cycles later.
    wb_xfer(0, 1'b1, 15'h4000, 32'h1, 4'hF, rd, lat);
    repeat (10) @(posedge clk);
`ifdef VRAM_FILL_IRQ_EN
    #1;
    chk("irq_before_restart", 32'(irq0), 32'd0);
`endif
    wb_xfer(0, 1'b1, 15'h4000, 32'h0, 4'hF, rd, lat);
    wb_xfer(0, 1'b0, 15'd127, '0, 4'hF, rd, lat);
    chk("restart_rd_lat", 32'(lat), 32'd128);
    chk("restart_rd_data", rd, 32'h0);
`ifdef VRAM_FILL_IRQ_EN
    chk("irq_after_restart", 32'(irq0), 32'd1);
    wb_xfer(0, 1'b0, 15'h4000, '0, 4'hF, rd, lat);
    chk("restart_fill_rd", rd, 32'h2);
    chk("irq_cleared2", 32'(irq0), 32'd0);
`endif
    pix_sweep(1'b0, bad);
    chk("pix_all_zeros", 32'(bad), 32'd0);

    // Reset in the middle of a fill.
    wb_xfer(0, 1'b1, 15'h4000, 32'h1, 4'hF, rd, lat);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack0), 32'd0);
    chk("midrst_dat", dat0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_xfer(0, 1'b0, 15'h4000, '0, 4'hF, rd, lat);
    chk("midrst_busy", rd, 32'h0);
    wb_xfer(0, 1'b0, 15'd0, '0, 4'hF, rd, lat);
    chk("midrst_vram_lat", 32'(lat), 32'd1);
    chk("midrst_word0", rd, 32'hFFFF_FFFF);
    wb_xfer(0, 1'b0, 15'd100, '0, 4'hF, rd, lat);
    chk("midrst_word100", rd, 32'h0);
`ifdef VRAM_FILL_IRQ_EN
    chk("midrst_irq", 32'(irq0), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
